vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 122 ++++++++++++
 tb/tb_vga_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// VGA timing generator with registered colour/sync outputs; optional frame_tick under VGA_SYNC_FRAME_TICK_EN.
// Latency: rgb_out/hsync/vsync lag (x,y) by one pixel period; free-running, no backpressure.
module vga_sync #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [7:0]  rgb_in,
    output logic [7:0]  rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    output logic        frame_tick
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        phase_q,   phase_d;
    logic [10:0] h_cnt_q,   h_cnt_d;
    logic [10:0] v_cnt_q,   v_cnt_d;
    logic [7:0]  rgb_out_q, rgb_out_d;
    logic        hsync_q,   hsync_d;
    logic        vsync_q,   vsync_d;
    logic        h_wrap;
    logic        v_wrap;

    assign pix_tick = phase_q;
    assign h_wrap   = (h_cnt_q == H_LAST);
    assign v_wrap   = (v_cnt_q == V_LAST);
    assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    assign x       = h_cnt_q;
    assign y       = v_cnt_q;
    assign rgb_out = rgb_out_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

    always_comb begin
        phase_d   = ~phase_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        rgb_out_d = rgb_out_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        if (pix_tick) begin
            // Sync and colour are sampled from the pre-increment position, so all
            // three outputs share the same one-pixel delay relative to (x,y).
            rgb_out_d = video_on ? rgb_in : 8'h00;
            hsync_d   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
            vsync_d   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
            if (h_wrap) begin
                h_cnt_d = 11'd0;
                v_cnt_d = v_wrap ? 11'd0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 1'b0;
            h_cnt_q   <= 11'd0;
            v_cnt_q   <= 11'd0;
            rgb_out_q <= 8'h00;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rgb_out_q <= rgb_out_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    localparam logic [10:0] V_VIS_LAST = 11'(V_VISIBLE - 1);

    logic frame_tick_q, frame_tick_d;

    // Single-clk pulse: recomputed every clk so it drops on the following non-tick cycle.
    always_comb begin
        frame_tick_d = pix_tick && h_wrap && (v_cnt_q == V_VIS_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Randomized bench for vga_sync using a small raster; expectations come from a cycle-count raster model.
module tb_vga_sync;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 12, VF = 3, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;   // 30
    localparam int VT = VV + VF + VS + VB;   // 21
    localparam int FRAME = HT * VT;          // 630 pixels, 1260 clk

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rgb_in = 8'h00;
    logic [10:0] x, y;
    logic [7:0]  rgb_out;
    logic        hsync, vsync, video_on, pix_tick;
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic        frame_tick;
`endif

    vga_sync #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .rgb_in(rgb_in), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .pix_tick(pix_tick)
`ifdef VGA_SYNC_FRAME_TICK_EN
        , .frame_tick(frame_tick)
`endif
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Raster model: everything derives from clk edges counted since reset release.
    int   cyc = 0;
    bit   mvalid = 1'b0;
    int   e_rgb = 0, e_hs = 1, e_vs = 1, e_ft = 0;

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; e_rgb = 0; e_hs = 1; e_vs = 1; e_ft = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            cyc++;
            e_ft = 0;
            if (cyc % 2 == 0) begin
                int q, qx, qy;
                q  = (cyc / 2 - 1) % FRAME;
                qx = q % HT;
                qy = q / HT;
                e_rgb = (qx < HV && qy < VV) ? int'(rgb_in) : 0;
                e_hs  = (qx >= HV + HF && qx < HV + HF + HS) ? 0 : 1;
                e_vs  = (qy >= VV + VF && qy < VV + VF + VS) ? 0 : 1;
                e_ft  = ((cyc / 2) % FRAME == VV * HT) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            int p, ex, ey;
            p  = (cyc / 2) % FRAME;
            ex = p % HT;
            ey = p / HT;
            chk("x", int'(x), ex);
            chk("y", int'(y), ey);
            chk("pix_tick", int'(pix_tick), cyc % 2);
            chk("video_on", int'(video_on), (ex < HV && ey < VV) ? 1 : 0);
            chk("rgb_out", int'(rgb_out), e_rgb);
            chk("hsync", int'(hsync), e_hs);
            chk("vsync", int'(vsync), e_vs);
`ifdef VGA_SYNC_FRAME_TICK_EN
            chk("frame_tick", int'(frame_tick), e_ft);
`endif
        end
    end

    // 0: random colour, 1: all-ones, 2: colour = x[7:0]
    int mode = 0;
    always @(negedge clk) begin
        case (mode)
            1:       rgb_in = 8'hFF;
            2:       rgb_in = x[7:0];
            default: rgb_in = 8'($urandom);
        endcase
    end

    initial begin
        int n_tick, n_ret, n_hlow, n_vlow, n_ft, prev_zero;
        bit found;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First tick one edge after release; first increment on the second edge.
        @(negedge clk);
        chk("first_tick_x", int'(x), 0);
        chk("first_tick_strobe", int'(pix_tick), 1);
        @(negedge clk);
        chk("first_inc_x", int'(x), 1);
        chk("first_inc_strobe", int'(pix_tick), 0);

        // One full frame of clks starting from pixel 1.
        n_tick = 0; n_ret = 0; n_hlow = 0; n_vlow = 0; n_ft = 0; prev_zero = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (pix_tick) n_tick++;
            if (x == 0 && y == 0 && !prev_zero) n_ret++;
            prev_zero = (x == 0 && y == 0) ? 1 : 0;
            if (pix_tick && !hsync) n_hlow++;
            if (pix_tick && !vsync) n_vlow++;
`ifdef VGA_SYNC_FRAME_TICK_EN
            if (frame_tick) n_ft++;
`endif
        end
        chk("frame_tick_strobes", n_tick, 630);
        chk("frame_returns_origin", n_ret, 1);
        chk("hsync_low_ticks", n_hlow, 126);
        chk("vsync_low_ticks", n_vlow, 60);
`ifdef VGA_SYNC_FRAME_TICK_EN
        chk("frame_tick_pulses", n_ft, 1);
`endif

        mode = 1;
        repeat (4 * FRAME) @(negedge clk);
        mode = 2;
        repeat (4 * FRAME) @(negedge clk);
        mode = 0;

        // Reset inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (x == 11'(HV + HF + 2) && y == 11'(VV + VF) && !hsync && !vsync) found = 1'b1;
        end
        chk("reset_point_reached", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_rgb", int'(rgb_out), 0);
        rst = 1'b0;

        // Random reset pulses at arbitrary points with mixed colour modes.
        for (int k = 0; k < 6; k++) begin
            mode = int'($urandom_range(0, 2));
            repeat ($urandom_range(1, 2 * FRAME)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst = 1'b0;
        end
        mode = 0;
        repeat (2 * FRAME + 10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
